// File: rtl/cache4_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache4_ctrl
// Summary  : 4-way set-associative write-back / write-allocate cache controller
//            with one-word lines and per-way 2-bit LRU counters.
// Revision : 1.0 - initial release
// ============================================================================
module cache4_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int INDEX_W = 2,
    parameter int DATA_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              hit,
    output logic              miss,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int c_TAG_W = ADDR_W - INDEX_W;
    localparam int c_SETS  = 1 << INDEX_W;
    localparam int c_WAYS  = 4;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOOKUP    = 3'd1,
        S_WRITEBACK = 3'd2,
        S_REFILL    = 3'd3,
        S_RESPOND   = 3'd4
    } state_t;

    state_t                          r_state;
    logic                            r_we;
    logic [ADDR_W-1:0]               r_addr;
    logic [DATA_W-1:0]               r_wdata;
    logic [1:0]                      r_victim;
    logic [c_WAYS-1:0]               r_valid [c_SETS];
    logic [c_WAYS-1:0]               r_dirty [c_SETS];
    logic [c_WAYS-1:0][c_TAG_W-1:0]  r_tag   [c_SETS];
    logic [c_WAYS-1:0][DATA_W-1:0]   r_data  [c_SETS];
    logic [c_WAYS-1:0][1:0]          r_lru   [c_SETS];

    logic [ADDR_W-1:0]               w_addr;
    logic [INDEX_W-1:0]              w_idx;
    logic [c_TAG_W-1:0]              w_tag;
    logic                            w_hit;
    logic [1:0]                      w_hit_way;
    logic [1:0]                      w_vict;
    logic                            w_vict_dirty;
    logic [1:0]                      w_acc_way;
    logic [c_WAYS-1:0][1:0]          w_lru_next;

    // In IDLE the lookup runs on the incoming address so hit/miss can be
    // registered at acceptance and show up during the LOOKUP cycle.
    always_comb begin
        w_addr    = (r_state == S_IDLE) ? cpu_addr : r_addr;
        w_idx     = w_addr[INDEX_W-1:0];
        w_tag     = w_addr[ADDR_W-1:INDEX_W];
        w_hit     = 1'b0;
        w_hit_way = 2'd0;
        for (int w = c_WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = 2'(w);
            end
        end
        // Oldest way first, then the lowest-index invalid way overrides it.
        w_vict = 2'd0;
        for (int w = c_WAYS - 1; w >= 0; w--) begin
            if (r_lru[w_idx][w] == 2'd0) w_vict = 2'(w);
        end
        for (int w = c_WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_idx][w]) w_vict = 2'(w);
        end
        w_vict_dirty = r_valid[w_idx][w_vict] & r_dirty[w_idx][w_vict];
        w_acc_way    = (r_state == S_LOOKUP) ? (w_hit ? w_hit_way : w_vict) : r_victim;
        w_lru_next   = r_lru[w_idx];
        for (int j = 0; j < c_WAYS; j++) begin
            if (2'(j) == w_acc_way)
                w_lru_next[j] = 2'd3;
            else if (r_lru[w_idx][j] > r_lru[w_idx][w_acc_way])
                w_lru_next[j] = r_lru[w_idx][j] - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_victim  <= 2'd0;
            cpu_ready <= 1'b1;
            cpu_done  <= 1'b0;
            cpu_rdata <= '0;
            hit       <= 1'b0;
            miss      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            for (int s = 0; s < c_SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                r_lru[s]   <= {2'd3, 2'd2, 2'd1, 2'd0};
            end
        end else begin
            hit      <= 1'b0;
            miss     <= 1'b0;
            cpu_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cpu_req) begin
                        r_we      <= cpu_we;
                        r_addr    <= cpu_addr;
                        r_wdata   <= cpu_wdata;
                        hit       <= w_hit;
                        miss      <= ~w_hit;
                        cpu_ready <= 1'b0;
                        r_state   <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    r_victim <= w_acc_way;
                    if (w_hit) begin
                        if (r_we) begin
                            r_data[w_idx][w_acc_way]  <= r_wdata;
                            r_dirty[w_idx][w_acc_way] <= 1'b1;
                        end else begin
                            cpu_rdata <= r_data[w_idx][w_acc_way];
                        end
                        r_lru[w_idx] <= w_lru_next;
                        cpu_done     <= 1'b1;
                        r_state      <= S_RESPOND;
                    end else if (w_vict_dirty) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {r_tag[w_idx][w_vict], w_idx};
                        mem_wdata <= r_data[w_idx][w_vict];
                        r_state   <= S_WRITEBACK;
                    end else if (!r_we) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= r_addr;
                        r_state  <= S_REFILL;
                    end else begin
                        r_tag[w_idx][w_acc_way]   <= w_tag;
                        r_data[w_idx][w_acc_way]  <= r_wdata;
                        r_valid[w_idx][w_acc_way] <= 1'b1;
                        r_dirty[w_idx][w_acc_way] <= 1'b1;
                        r_lru[w_idx]              <= w_lru_next;
                        cpu_done                  <= 1'b1;
                        r_state                   <= S_RESPOND;
                    end
                end
                S_WRITEBACK: begin
                    if (mem_ack) begin
                        if (r_we) begin
                            r_tag[w_idx][w_acc_way]   <= w_tag;
                            r_data[w_idx][w_acc_way]  <= r_wdata;
                            r_valid[w_idx][w_acc_way] <= 1'b1;
                            r_dirty[w_idx][w_acc_way] <= 1'b1;
                            r_lru[w_idx]              <= w_lru_next;
                            mem_req                   <= 1'b0;
                            mem_we                    <= 1'b0;
                            cpu_done                  <= 1'b1;
                            r_state                   <= S_RESPOND;
                        end else begin
                            mem_we   <= 1'b0;
                            mem_addr <= r_addr;
                            r_state  <= S_REFILL;
                        end
                    end
                end
                S_REFILL: begin
                    if (mem_ack) begin
                        r_tag[w_idx][w_acc_way]   <= w_tag;
                        r_data[w_idx][w_acc_way]  <= mem_rdata;
                        r_valid[w_idx][w_acc_way] <= 1'b1;
                        r_dirty[w_idx][w_acc_way] <= 1'b0;
                        r_lru[w_idx]              <= w_lru_next;
                        cpu_rdata                 <= mem_rdata;
                        mem_req                   <= 1'b0;
                        cpu_done                  <= 1'b1;
                        r_state                   <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    cpu_ready <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: begin
                    cpu_ready <= 1'b1;
                    mem_req   <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire
